// File: rtl/fwd_pkg.sv
// Shared types and defaults for the ID-stage forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_NUM_SRC    = 3;
    localparam int DEF_HIST_DEPTH = 2;
    localparam int SEL_W          = $clog2(DEF_NUM_SRC + DEF_HIST_DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fwd_state_e;

    typedef struct packed {
        logic                valid;
        logic [4:0]          addr;
        logic [DEF_XLEN-1:0] data;
    } hist_entry_t;

    // Select code 0 is the RF, then one code per stage, then one per history entry.
    function automatic int sel_width(input int num_src, input int hist_depth);
        return $clog2(num_src + hist_depth + 1);
    endfunction

endpackage

// File: rtl/fwd_wb_history.sv
// Push-shift record of retired WB writes; entry 0 is the newest, the oldest falls off the end.
module fwd_wb_history #(
    parameter  int XLEN       = 32,
    parameter  int HIST_DEPTH = 2,
    localparam int ENTRY_W    = XLEN + 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [4:0]                    push_addr_i,
    input  logic [XLEN-1:0]               push_data_i,
    output logic [HIST_DEPTH*ENTRY_W-1:0] entries_o
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t [HIST_DEPTH-1:0] hist_q;
    entry_t [HIST_DEPTH-1:0] hist_d;

    always_comb begin
        hist_d = hist_q;
        if (push_i) begin
            hist_d[0] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign entries_o = hist_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand bypass from pipeline stages and retired-WB history, plus load-use stall control.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int XLEN              = 32,
    parameter  int NUM_SRC           = 3,
    parameter  int HIST_DEPTH        = 2,
    parameter  int LOAD_STALL_CYCLES = 1,
    parameter  int CNT_W             = 16,
    localparam int SEL_BITS          = sel_width(NUM_SRC, HIST_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_in,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*5-1:0]      src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    input  logic                      ex_is_load,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic [XLEN-1:0]           rs1_data_rf,
    input  logic [XLEN-1:0]           rs2_data_rf,
    output logic [XLEN-1:0]           rs1_data_out,
    output logic [XLEN-1:0]           rs2_data_out,
    output logic [SEL_BITS-1:0]       rs1_fwd_sel,
    output logic [SEL_BITS-1:0]       rs2_fwd_sel,
    output logic                      hazard_detected,
    output logic                      bubble_out,
    output logic [CNT_W-1:0]          hazard_count,
    output fwd_state_e                dbg_state
);

    localparam int ENTRY_W = XLEN + 6;
    localparam int CW      = $clog2(LOAD_STALL_CYCLES + 1);

    // ---------------- retired-WB history ----------------
    logic                          wb_push;
    logic [HIST_DEPTH*ENTRY_W-1:0] hist_flat;
    logic                          hist_valid [HIST_DEPTH];
    logic [4:0]                    hist_addr  [HIST_DEPTH];
    logic [XLEN-1:0]               hist_data  [HIST_DEPTH];

    assign wb_push = !stall_in && src_valid[NUM_SRC-1]
                     && (src_addr[5*(NUM_SRC-1) +: 5] != 5'd0);

    fwd_wb_history #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wb_push),
        .push_addr_i (src_addr[5*(NUM_SRC-1) +: 5]),
        .push_data_i (src_data[XLEN*(NUM_SRC-1) +: XLEN]),
        .entries_o   (hist_flat)
    );

    always_comb begin
        for (int j = 0; j < HIST_DEPTH; j++) begin
            hist_valid[j] = hist_flat[j*ENTRY_W + ENTRY_W - 1];
            hist_addr[j]  = hist_flat[j*ENTRY_W + XLEN +: 5];
            hist_data[j]  = hist_flat[j*ENTRY_W +: XLEN];
        end
    end

    // ---------------- operand forwarding ----------------
    logic [NUM_SRC-1:0]  src_fwd_ok;
    logic [4:0]          rs_addr [2];
    logic [XLEN-1:0]     rs_rf   [2];
    logic [XLEN-1:0]     rs_out  [2];
    logic [SEL_BITS-1:0] rs_sel  [2];

    // A load in EX has no data yet, so it must never be a bypass source.
    always_comb begin
        src_fwd_ok    = src_valid;
        src_fwd_ok[0] = src_valid[0] & ~ex_is_load;
    end

    always_comb begin
        rs_addr[0] = rs1_addr;
        rs_addr[1] = rs2_addr;
        rs_rf[0]   = rs1_data_rf;
        rs_rf[1]   = rs2_data_rf;
    end

    // Lowest priority first so each later hit overrides; the youngest stage ends up winning.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            rs_out[op] = rs_rf[op];
            rs_sel[op] = '0;
            if (rs_addr[op] != 5'd0) begin
                for (int j = HIST_DEPTH - 1; j >= 0; j--) begin
                    if (hist_valid[j] && (hist_addr[j] == rs_addr[op])) begin
                        rs_out[op] = hist_data[j];
                        rs_sel[op] = SEL_BITS'(NUM_SRC + 1 + j);
                    end
                end
                for (int i = NUM_SRC - 1; i >= 0; i--) begin
                    if (src_fwd_ok[i] && (src_addr[5*i +: 5] == rs_addr[op])) begin
                        rs_out[op] = src_data[XLEN*i +: XLEN];
                        rs_sel[op] = SEL_BITS'(i + 1);
                    end
                end
            end
        end
    end

    assign rs1_data_out = rs_out[0];
    assign rs2_data_out = rs_out[1];
    assign rs1_fwd_sel  = rs_sel[0];
    assign rs2_fwd_sel  = rs_sel[1];

    // ---------------- load-use stall FSM ----------------
    logic       load_use;
    logic [4:0] ex_rd;

    assign ex_rd    = src_addr[4:0];
    assign load_use = ex_is_load && src_valid[0] && (ex_rd != 5'd0)
                      && ((rs1_used && (rs1_addr == ex_rd)) || (rs2_used && (rs2_addr == ex_rd)));

    fwd_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           haz_raw;
    logic [CNT_W-1:0] hazard_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The detection cycle is the first stall cycle, so STALL covers the remaining LOAD_STALL_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        haz_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                haz_raw = load_use;
                if (load_use && (LOAD_STALL_CYCLES > 1) && !stall_in) begin
                    state_d = STALL;
                    cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
                end
            end
            STALL: begin
                haz_raw = 1'b1;
                if (!stall_in) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_count_q <= '0;
        end else if (haz_raw && (hazard_count_q != {CNT_W{1'b1}})) begin
            hazard_count_q <= hazard_count_q + 1'b1;
        end
    end

    assign hazard_detected = haz_raw & ~rst;
    assign bubble_out      = hazard_detected;
    assign hazard_count    = hazard_count_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (1-cycle stall, 3-cycle stall, 2-bit counter) share inputs.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int NSRC = 3;
    localparam int HD   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall_in;
    logic [2:0]  src_valid;
    logic [14:0] src_addr;
    logic [95:0] src_data;
    logic        ex_is_load;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic [31:0] rs1_data_rf, rs2_data_rf;

    logic [31:0] o_rs1 [3];
    logic [31:0] o_rs2 [3];
    logic [2:0]  o_s1  [3];
    logic [2:0]  o_s2  [3];
    logic        o_haz [3];
    logic        o_bub [3];
    logic [15:0] o_cnt [3];
    fwd_state_e  o_st  [3];
    logic [1:0]  c_cnt;
    assign o_cnt[2] = 16'(c_cnt);

    fwd_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .stall_in(stall_in), .src_valid(src_valid), .src_addr(src_addr),
        .src_data(src_data), .ex_is_load(ex_is_load), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_data_rf(rs1_data_rf), .rs2_data_rf(rs2_data_rf),
        .rs1_data_out(o_rs1[0]), .rs2_data_out(o_rs2[0]), .rs1_fwd_sel(o_s1[0]), .rs2_fwd_sel(o_s2[0]),
        .hazard_detected(o_haz[0]), .bubble_out(o_bub[0]), .hazard_count(o_cnt[0]), .dbg_state(o_st[0])
    );

    fwd_hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .stall_in(stall_in), .src_valid(src_valid), .src_addr(src_addr),
        .src_data(src_data), .ex_is_load(ex_is_load), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_data_rf(rs1_data_rf), .rs2_data_rf(rs2_data_rf),
        .rs1_data_out(o_rs1[1]), .rs2_data_out(o_rs2[1]), .rs1_fwd_sel(o_s1[1]), .rs2_fwd_sel(o_s2[1]),
        .hazard_detected(o_haz[1]), .bubble_out(o_bub[1]), .hazard_count(o_cnt[1]), .dbg_state(o_st[1])
    );

    fwd_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .stall_in(stall_in), .src_valid(src_valid), .src_addr(src_addr),
        .src_data(src_data), .ex_is_load(ex_is_load), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_data_rf(rs1_data_rf), .rs2_data_rf(rs2_data_rf),
        .rs1_data_out(o_rs1[2]), .rs2_data_out(o_rs2[2]), .rs1_fwd_sel(o_s1[2]), .rs2_fwd_sel(o_s2[2]),
        .hazard_detected(o_haz[2]), .bubble_out(o_bub[2]), .hazard_count(c_cnt), .dbg_state(o_st[2])
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } hrec_t;

    hrec_t hist_m[$];
    int    lsc_m  [3] = '{1, 3, 1};
    int    cmax_m [3] = '{65535, 65535, 3};
    int    rem_m  [3];
    int    cnt_m  [3];

    function automatic logic load_use_m();
        logic [4:0] rd;
        rd = src_addr[4:0];
        return ex_is_load && src_valid[0] && (rd != 0) &&
               ((rs1_used && rs1_addr == rd) || (rs2_used && rs2_addr == rd));
    endfunction

    // First hit in priority order: stages youngest to oldest, then history newest to oldest.
    task automatic fwd_m(input logic [4:0] a, input logic [31:0] rf,
                         output logic [31:0] d, output logic [2:0] s);
        d = rf;
        s = 3'd0;
        if (a == 5'd0) return;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i] && !(i == 0 && ex_is_load) && src_addr[5*i +: 5] == a) begin
                d = src_data[32*i +: 32];
                s = 3'(i + 1);
                return;
            end
        end
        for (int j = 0; j < hist_m.size(); j++) begin
            if (hist_m[j].addr == a) begin
                d = hist_m[j].data;
                s = 3'(NSRC + 1 + j);
                return;
            end
        end
    endtask

    task automatic model_reset();
        hist_m.delete();
        for (int k = 0; k < 3; k++) begin
            rem_m[k] = 0;
            cnt_m[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic  lu;
        hrec_t r;
        lu = load_use_m();
        for (int k = 0; k < 3; k++) begin
            if (rem_m[k] > 0 || lu) cnt_m[k] = (cnt_m[k] < cmax_m[k]) ? cnt_m[k] + 1 : cnt_m[k];
            if (rem_m[k] > 0) begin
                if (!stall_in) rem_m[k]--;
            end else if (lu && !stall_in) begin
                rem_m[k] = lsc_m[k] - 1;
            end
        end
        if (!stall_in && src_valid[2] && src_addr[14:10] != 5'd0) begin
            r.addr = src_addr[14:10];
            r.data = src_data[95:64];
            hist_m.push_front(r);
            if (hist_m.size() > HD) void'(hist_m.pop_back());
        end
    endtask

    task automatic check_model();
        logic [31:0] d1, d2;
        logic [2:0]  s1, s2;
        logic        h;
        fwd_m(rs1_addr, rs1_data_rf, d1, s1);
        fwd_m(rs2_addr, rs2_data_rf, d2, s2);
        for (int k = 0; k < 3; k++) begin
            h = (rem_m[k] > 0) || load_use_m();
            check($sformatf("u%0d rs1_data", k), o_rs1[k], d1);
            check($sformatf("u%0d rs1_sel", k), 32'(o_s1[k]), 32'(s1));
            check($sformatf("u%0d rs2_data", k), o_rs2[k], d2);
            check($sformatf("u%0d rs2_sel", k), 32'(o_s2[k]), 32'(s2));
            check($sformatf("u%0d hazard", k), 32'(o_haz[k]), 32'(h));
            check($sformatf("u%0d bubble", k), 32'(o_bub[k]), 32'(h));
            check($sformatf("u%0d count", k), 32'(o_cnt[k]), 32'(cnt_m[k]));
            check($sformatf("u%0d stalling", k), 32'(o_st[k] == STALL), 32'(rem_m[k] > 0));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic quiet();
        stall_in    = 1'b0;
        src_valid   = '0;
        src_addr    = '0;
        src_data    = '0;
        ex_is_load  = 1'b0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        rs1_data_rf = '0;
        rs2_data_rf = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic tick(input bit chk);
        @(negedge clk);
        if (chk) check_model();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_x7();
        src_valid  = 3'b001;
        src_addr   = 15'd7;
        src_data   = {64'h0, 32'h77};
        ex_is_load = 1'b1;
        rs1_addr   = 5'd7;
        rs1_used   = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  sv;
        logic [14:0] sa;
        logic [95:0] sd;
        logic        ld;
        logic [4:0]  r1, r2;
        logic [31:0] f1, f2;
        logic [31:0] e1;
        logic [2:0]  s1;
        logic [31:0] e2;
        logic [2:0]  s2;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b110, {5'd5, 5'd5, 5'd0}, {32'hBBBB, 32'hAAAA, 32'h0}, 1'b0, 5'd5, 5'd3,
                   32'h11, 32'h33, 32'hAAAA, 3'd2, 32'h33, 3'd0};
        tbl[1] = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 3'd0, 32'h0, 3'd0};
        tbl[2] = '{3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h88, 32'h77}, 1'b1, 5'd7, 5'd7,
                   32'h1, 32'h2, 32'h88, 3'd2, 32'h88, 3'd2};
        tbl[3] = '{3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h88, 32'h77}, 1'b0, 5'd7, 5'd7,
                   32'h1, 32'h2, 32'h77, 3'd1, 32'h77, 3'd1};
        tbl[4] = '{3'b100, {5'd12, 5'd0, 5'd0}, {32'hC0DE, 64'h0}, 1'b0, 5'd12, 5'd13,
                   32'h1, 32'h5, 32'hC0DE, 3'd3, 32'h5, 3'd0};
        tbl[5] = '{3'b110, {5'd4, 5'd4, 5'd4}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd4, 5'd6,
                   32'h1, 32'h66, 32'h2, 3'd2, 32'h66, 3'd0};
        tbl[6] = '{3'b111, {5'd4, 5'd4, 5'd4}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd4, 5'd4,
                   32'h1, 32'h66, 32'h1, 3'd1, 32'h1, 3'd1};

        // Reset state, sampled while reset is held.
        rst = 1'b1;
        quiet();
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset u%0d hazard", k), 32'(o_haz[k]), 32'd0);
            check($sformatf("reset u%0d count", k), 32'(o_cnt[k]), 32'd0);
            check($sformatf("reset u%0d state", k), 32'(o_st[k]), 32'(IDLE));
        end
        do_reset();

        // Table: stall_in held so the history stays empty between rows.
        for (int v = 0; v < 7; v++) begin
            quiet();
            stall_in    = 1'b1;
            src_valid   = tbl[v].sv;
            src_addr    = tbl[v].sa;
            src_data    = tbl[v].sd;
            ex_is_load  = tbl[v].ld;
            rs1_addr    = tbl[v].r1;
            rs2_addr    = tbl[v].r2;
            rs1_data_rf = tbl[v].f1;
            rs2_data_rf = tbl[v].f2;
            @(negedge clk);
            check($sformatf("vec%0d rs1_data", v), o_rs1[0], tbl[v].e1);
            check($sformatf("vec%0d rs1_sel", v), 32'(o_s1[0]), 32'(tbl[v].s1));
            check($sformatf("vec%0d rs2_data", v), o_rs2[0], tbl[v].e2);
            check($sformatf("vec%0d rs2_sel", v), 32'(o_s2[0]), 32'(tbl[v].s2));
            next_cycle();
        end

        // Single-cycle load-use on u_a, then the same operand without rs1_used.
        do_reset();
        load_use_x7();
        @(negedge clk);
        check("lu1 hazard", 32'(o_haz[0]), 32'd1);
        check("lu1 bubble", 32'(o_bub[0]), 32'd1);
        check("lu1 count0", 32'(o_cnt[0]), 32'd0);
        next_cycle();
        ex_is_load = 1'b0;
        @(negedge clk);
        check("lu1 hazard after", 32'(o_haz[0]), 32'd0);
        check("lu1 count1", 32'(o_cnt[0]), 32'd1);
        check("lu1 fwd data", o_rs1[0], 32'h77);
        check("lu1 fwd sel", 32'(o_s1[0]), 32'd1);
        next_cycle();
        ex_is_load = 1'b1;
        rs1_used   = 1'b0;
        @(negedge clk);
        check("lu unused hazard", 32'(o_haz[0]), 32'd0);

        // Three-cycle stall on u_b with a downstream freeze on the second hazard cycle.
        do_reset();
        load_use_x7();
        @(negedge clk);
        check("lu3 c1 hazard", 32'(o_haz[1]), 32'd1);
        next_cycle();
        stall_in   = 1'b1;
        ex_is_load = 1'b0;
        @(negedge clk);
        check("lu3 c2 hazard", 32'(o_haz[1]), 32'd1);
        next_cycle();
        stall_in = 1'b0;
        @(negedge clk);
        check("lu3 c3 hazard", 32'(o_haz[1]), 32'd1);
        check("lu3 c3 state", 32'(o_st[1]), 32'(STALL));
        next_cycle();
        @(negedge clk);
        check("lu3 c4 hazard", 32'(o_haz[1]), 32'd1);
        next_cycle();
        @(negedge clk);
        check("lu3 c5 hazard", 32'(o_haz[1]), 32'd0);
        check("lu3 c5 state", 32'(o_st[1]), 32'(IDLE));
        check("lu3 count", 32'(o_cnt[1]), 32'd4);

        // History: x9 retires, then ages out after two more writes.
        do_reset();
        src_valid = 3'b100;
        src_addr  = {5'd9, 10'd0};
        src_data  = {32'hCAFE, 64'h0};
        rs1_addr  = 5'd9;
        @(negedge clk);
        check("hist wb data", o_rs1[0], 32'hCAFE);
        check("hist wb sel", 32'(o_s1[0]), 32'd3);
        next_cycle();
        src_valid = 3'b000;
        @(negedge clk);
        check("hist0 data", o_rs1[0], 32'hCAFE);
        check("hist0 sel", 32'(o_s1[0]), 32'd4);
        next_cycle();
        src_valid = 3'b100;
        src_addr  = {5'd10, 10'd0};
        src_data  = {32'h1010, 64'h0};
        next_cycle();
        src_valid = 3'b000;
        rs2_addr  = 5'd10;
        @(negedge clk);
        check("hist1 data", o_rs1[0], 32'hCAFE);
        check("hist1 sel", 32'(o_s1[0]), 32'd5);
        check("hist0 x10 data", o_rs2[0], 32'h1010);
        check("hist0 x10 sel", 32'(o_s2[0]), 32'd4);
        src_valid = 3'b100;
        src_addr  = {5'd11, 10'd0};
        src_data  = {32'h1111, 64'h0};
        next_cycle();
        src_valid   = 3'b000;
        rs1_data_rf = 32'h5;
        @(negedge clk);
        check("hist aged data", o_rs1[0], 32'h5);
        check("hist aged sel", 32'(o_s1[0]), 32'd0);
        check("hist x10 old sel", 32'(o_s2[0]), 32'd5);

        // Reset in the middle of a u_b stall.
        do_reset();
        load_use_x7();
        src_valid = 3'b101;
        src_addr  = {5'd9, 5'd0, 5'd7};
        src_data  = {32'hCAFE, 32'h0, 32'h77};
        next_cycle();
        src_valid   = 3'b000;
        ex_is_load  = 1'b0;
        rs2_addr    = 5'd9;
        rs2_data_rf = 32'h5;
        @(negedge clk);
        check("rst pre hazard", 32'(o_haz[1]), 32'd1);
        check("rst pre hist", o_rs2[0], 32'hCAFE);
        #1;
        rst = 1'b1;
        load_use_x7();
        #1;
        check("rst hazard u_b", 32'(o_haz[1]), 32'd0);
        check("rst bubble u_b", 32'(o_bub[1]), 32'd0);
        check("rst hazard u_a", 32'(o_haz[0]), 32'd0);
        check("rst count u_b", 32'(o_cnt[1]), 32'd0);
        check("rst state u_b", 32'(o_st[1]), 32'(IDLE));
        check("rst hist data", o_rs2[0], 32'h5);
        check("rst hist sel", 32'(o_s2[0]), 32'd0);
        quiet();
        next_cycle();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("post rst hazard u_b", 32'(o_haz[1]), 32'd0);

        // Counter saturation on the 2-bit u_c.
        do_reset();
        load_use_x7();
        for (int n = 1; n <= 5; n++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("sat c%0d", n), 32'(c_cnt), 32'((n < 3) ? n : 3));
        end
        check("sat wide count", 32'(o_cnt[0]), 32'd5);

        // Random traffic against the reference model.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset();
            src_valid  = 3'($urandom_range(0, 7));
            for (int i = 0; i < NSRC; i++) begin
                src_addr[5*i +: 5]  = 5'($urandom_range(0, 7));
                src_data[32*i +: 32] = $urandom;
            end
            ex_is_load  = ($urandom_range(0, 3) == 0);
            stall_in    = ($urandom_range(0, 4) == 0);
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            rs1_used    = 1'($urandom_range(0, 1));
            rs2_used    = 1'($urandom_range(0, 1));
            rs1_data_rf = (rs1_addr == 0) ? 32'h0 : $urandom;
            rs2_data_rf = (rs2_addr == 0) ? 32'h0 : $urandom;
            tick(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
